// File: rtl/pipe_hazard_ctrl.sv
// Y86 five-stage pipeline hazard/control unit: stall and bubble generation,
// bounded data-memory wait, sticky HALT on exception, saturating hazard counters.
module pipe_hazard_ctrl #(
  parameter int               REG_W       = 4,
  parameter int               STAT_W      = 2,
  parameter logic [REG_W-1:0] RNONE       = 4'hF,
  parameter int               MEM_TIMEOUT = 16,
  parameter int               CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_D_icode,
  input  logic [REG_W-1:0]  i_d_srcA,
  input  logic [REG_W-1:0]  i_d_srcB,
  input  logic [3:0]        i_E_icode,
  input  logic [REG_W-1:0]  i_E_dstM,
  input  logic              i_e_cnd,
  input  logic [3:0]        i_M_icode,
  input  logic [STAT_W-1:0] i_m_stat,
  input  logic [STAT_W-1:0] i_W_stat,
  input  logic              i_m_mem_req,
  input  logic              i_m_mem_ack,
  output logic              o_F_stall,
  output logic              o_D_stall,
  output logic              o_D_bubble,
  output logic              o_E_stall,
  output logic              o_E_bubble,
  output logic              o_M_stall,
  output logic              o_M_bubble,
  output logic              o_W_stall,
  output logic              o_W_bubble,
  output logic              o_set_cc,
  output logic              o_halted,
  output logic              o_mem_err,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_mispred_cnt,
  output logic [CNT_W-1:0]  o_loaduse_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_mispred_cnt;
  logic [CNT_W-1:0]  r_loaduse_cnt;

  logic w_load_use;
  logic w_mispred;
  logic w_ret_haz;
  logic w_m_exc;
  logic w_w_exc;
  logic w_mem_hold;

  // A load whose destination is RNONE writes nothing, so it can never conflict.
  assign w_load_use = ((i_E_icode == I_MRMOVQ) || (i_E_icode == I_POPQ)) &&
                      (i_E_dstM != RNONE) &&
                      ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
  assign w_mispred  = (i_E_icode == I_JXX) && !i_e_cnd;
  assign w_ret_haz  = (i_D_icode == I_RET) || (i_E_icode == I_RET) || (i_M_icode == I_RET);
  assign w_m_exc    = (i_m_stat != '0);
  assign w_w_exc    = (i_W_stat != '0);
  assign w_mem_hold = i_m_mem_req && !i_m_mem_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_w_exc) begin
            r_state <= ST_HALT;
          end else if (w_mem_hold) begin
            r_state    <= ST_MWAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MWAIT: begin
          if (w_w_exc) begin
            r_state <= ST_HALT;
          end else if (!w_mem_hold) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_MAX) begin
            r_state   <= ST_HALT;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is held, whatever the stage inputs show.
  always_comb begin
    o_F_stall  = 1'b0;
    o_D_stall  = 1'b0;
    o_D_bubble = 1'b0;
    o_E_stall  = 1'b0;
    o_E_bubble = 1'b0;
    o_M_stall  = 1'b0;
    o_M_bubble = 1'b0;
    o_W_stall  = 1'b0;
    o_W_bubble = 1'b0;
    o_set_cc   = 1'b0;
    o_halted   = 1'b0;
    if (i_rst_n) begin
      if (r_state == ST_HALT) begin
        o_halted  = 1'b1;
        o_F_stall = 1'b1;
        o_D_stall = 1'b1;
        o_E_stall = 1'b1;
        o_M_stall = 1'b1;
        o_W_stall = 1'b1;
      end else if (w_mem_hold) begin
        o_F_stall = 1'b1;
        o_D_stall = 1'b1;
        o_E_stall = 1'b1;
        o_M_stall = 1'b1;
        if (w_w_exc) begin
          o_W_stall = 1'b1;
        end else begin
          o_W_bubble = 1'b1;
        end
      end else begin
        o_F_stall  = w_load_use || w_ret_haz;
        o_D_stall  = w_load_use;
        o_D_bubble = w_mispred || (w_ret_haz && !w_load_use);
        o_E_bubble = w_mispred || w_load_use;
        o_M_bubble = w_m_exc || w_w_exc;
        o_W_stall  = w_w_exc;
        o_set_cc   = (i_E_icode == I_OPQ) && !w_m_exc && !w_w_exc;
      end
    end
  end

  // Counters freeze in HALT so the snapshot at the point of failure survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt   <= '0;
      r_mispred_cnt <= '0;
      r_loaduse_cnt <= '0;
    end else if (r_state != ST_HALT) begin
      if (o_F_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_mispred && !w_mem_hold && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
      if (w_load_use && !w_mem_hold && (r_loaduse_cnt != '1)) begin
        r_loaduse_cnt <= r_loaduse_cnt + CNT_W'(1);
      end
    end
  end

  assign o_mem_err     = r_mem_err;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_mispred_cnt = r_mispred_cnt;
  assign o_loaduse_cnt = r_loaduse_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a rule-level model compared every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  localparam logic [3:0] NOP   = 4'h1;
  localparam logic [3:0] MRMOV = 4'h5;
  localparam logic [3:0] OPQ   = 4'h6;
  localparam logic [3:0] JXX   = 4'h7;
  localparam logic [3:0] RET   = 4'h9;
  localparam logic [3:0] POPQ  = 4'hB;
  localparam logic [3:0] RN    = 4'hF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] dIcode, dSrcA, dSrcB, eIcode, eDstM, mIcode;
  logic eCnd;
  logic [1:0] mStat, wStat;
  logic memReq, memAck;

  logic fStall, dStall, dBubble, eStall, eBubble, mStall, mBubble, wStall, wBubble;
  logic setCc, halted, memErr;
  logic [CW-1:0] stallCnt, mispredCnt, loadUseCnt;

  int errors = 0;
  int checks = 0;

  // Model state: consecutive memory-hold cycles replace any notion of FSM state.
  bit modelHalted = 1'b0;
  bit modelMemErr = 1'b0;
  int holdRun = 0;
  int stallCount = 0;
  int mispredCount = 0;
  int loadUseCount = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W(4), .STAT_W(2), .RNONE(4'hF), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_D_icode(dIcode), .i_d_srcA(dSrcA), .i_d_srcB(dSrcB),
    .i_E_icode(eIcode), .i_E_dstM(eDstM), .i_e_cnd(eCnd),
    .i_M_icode(mIcode), .i_m_stat(mStat), .i_W_stat(wStat),
    .i_m_mem_req(memReq), .i_m_mem_ack(memAck),
    .o_F_stall(fStall), .o_D_stall(dStall), .o_D_bubble(dBubble),
    .o_E_stall(eStall), .o_E_bubble(eBubble),
    .o_M_stall(mStall), .o_M_bubble(mBubble),
    .o_W_stall(wStall), .o_W_bubble(wBubble),
    .o_set_cc(setCc), .o_halted(halted), .o_mem_err(memErr),
    .o_stall_cnt(stallCnt), .o_mispred_cnt(mispredCnt), .o_loaduse_cnt(loadUseCnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] e, input logic [3:0] ed, input logic c,
                               input logic [3:0] m, input logic [1:0] ms, input logic [1:0] ws,
                               input logic req, input logic ack);
    @(posedge clk);
    #1;
    dIcode = d; dSrcA = sa; dSrcB = sb; eIcode = e; eDstM = ed; eCnd = c;
    mIcode = m; mStat = ms; wStat = ws; memReq = req; memAck = ack;
    @(negedge clk);
  endtask

  task automatic applyIdle();
    applyStimulus(NOP, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic driveReset(input logic level);
    @(posedge clk);
    #1;
    rst_n = level;
    @(negedge clk);
  endtask

  function automatic int satInc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Expected controls come straight from the hazard rules; the compare runs every cycle.
  always @(negedge clk) begin : modelCompare
    logic lu, mp, rh, mex, wex, hold;
    logic [11:0] expCtrl;
    logic [11:0] actCtrl;
    lu   = ((eIcode == MRMOV) || (eIcode == POPQ)) && (eDstM != RN) &&
           ((eDstM == dSrcA) || (eDstM == dSrcB));
    mp   = (eIcode == JXX) && !eCnd;
    rh   = (dIcode == RET) || (eIcode == RET) || (mIcode == RET);
    mex  = (mStat != 2'd0);
    wex  = (wStat != 2'd0);
    hold = memReq && !memAck;
    // Bit order: F_stall D_stall D_bubble E_stall E_bubble M_stall M_bubble W_stall W_bubble set_cc halted mem_err
    expCtrl = '0;
    if (rst_n) begin
      if (modelHalted) begin
        expCtrl = 12'b1101010100_1_0;
      end else if (hold) begin
        expCtrl = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, wex, !wex, 1'b0, 1'b0, 1'b0};
      end else begin
        expCtrl = {lu | rh, lu, mp | (rh & !lu), 1'b0, mp | lu, 1'b0, mex | wex,
                   wex, 1'b0, (eIcode == OPQ) & !mex & !wex, 1'b0, 1'b0};
      end
      expCtrl[0] = modelMemErr;
    end
    actCtrl = {fStall, dStall, dBubble, eStall, eBubble, mStall, mBubble,
               wStall, wBubble, setCc, halted, memErr};
    checkOutput("modelCtrl", 32'(actCtrl), 32'(expCtrl));
    checkOutput("modelStallCnt", 32'(stallCnt), 32'(rst_n ? stallCount : 0));
    checkOutput("modelMispredCnt", 32'(mispredCnt), 32'(rst_n ? mispredCount : 0));
    checkOutput("modelLoadUseCnt", 32'(loadUseCnt), 32'(rst_n ? loadUseCount : 0));

    if (!rst_n) begin
      modelHalted = 1'b0; modelMemErr = 1'b0; holdRun = 0;
      stallCount = 0; mispredCount = 0; loadUseCount = 0;
    end else if (!modelHalted) begin
      if (expCtrl[11]) stallCount = satInc(stallCount);
      if (mp && !hold) mispredCount = satInc(mispredCount);
      if (lu && !hold) loadUseCount = satInc(loadUseCount);
      holdRun = hold ? holdRun + 1 : 0;
      if (wex) begin
        modelHalted = 1'b1;
      end else if (holdRun == TIMEOUT + 1) begin
        modelHalted = 1'b1;
        modelMemErr = 1'b1;
      end
    end
  end

  initial begin
    dIcode = NOP; dSrcA = 4'd3; dSrcB = RN; eIcode = MRMOV; eDstM = 4'd3; eCnd = 1'b1;
    mIcode = NOP; mStat = 2'd0; wStat = 2'd0; memReq = 1'b0; memAck = 1'b0;

    // Load-use pattern during reset must not leak out.
    @(negedge clk);
    checkOutput("rstFStall", 32'(fStall), 0);
    checkOutput("rstEBubble", 32'(eBubble), 0);
    checkOutput("rstHalted", 32'(halted), 0);
    checkOutput("rstStallCnt", 32'(stallCnt), 0);
    applyIdle();
    driveReset(1'b1);

    applyStimulus(NOP, 4'd3, RN, MRMOV, 4'd3, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("luFStall", 32'(fStall), 1);
    checkOutput("luDStall", 32'(dStall), 1);
    checkOutput("luEBubble", 32'(eBubble), 1);
    checkOutput("luDBubble", 32'(dBubble), 0);
    checkOutput("luCntBefore", 32'(loadUseCnt), 0);
    applyIdle();
    checkOutput("luCntAfter", 32'(loadUseCnt), 1);
    checkOutput("idleFStall", 32'(fStall), 0);

    applyStimulus(NOP, 4'd0, RN, POPQ, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("rnoneFStall", 32'(fStall), 0);
    checkOutput("rnoneDStall", 32'(dStall), 0);
    checkOutput("rnoneEBubble", 32'(eBubble), 0);

    applyStimulus(RET, RN, RN, JXX, RN, 1'b0, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("mpRetFStall", 32'(fStall), 1);
    checkOutput("mpRetDBubble", 32'(dBubble), 1);
    checkOutput("mpRetEBubble", 32'(eBubble), 1);
    checkOutput("mpRetDStall", 32'(dStall), 0);
    applyIdle();
    checkOutput("mpCnt", 32'(mispredCnt), 1);

    applyStimulus(RET, 4'd3, RN, MRMOV, 4'd3, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("luRetDStall", 32'(dStall), 1);
    checkOutput("luRetDBubble", 32'(dBubble), 0);

    applyStimulus(NOP, RN, RN, OPQ, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("opqSetCc", 32'(setCc), 1);

    // Memory wait with a mispredict in E that must be suppressed.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(NOP, RN, RN, JXX, RN, 1'b0, NOP, 2'd0, 2'd0, 1'b1, 1'b0);
      checkOutput("waitStalls", 32'({fStall, dStall, eStall, mStall}), 32'hF);
      checkOutput("waitWBubble", 32'(wBubble), 1);
      checkOutput("waitEBubble", 32'(eBubble), 0);
    end
    applyStimulus(NOP, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b1, 1'b1);
    checkOutput("ackFStall", 32'(fStall), 0);
    checkOutput("ackWBubble", 32'(wBubble), 0);
    applyIdle();
    checkOutput("waitMemErr", 32'(memErr), 0);
    checkOutput("waitHalted", 32'(halted), 0);
    checkOutput("waitMpCnt", 32'(mispredCnt), 1);
    checkOutput("stallCnt6", 32'(stallCnt), 6);

    // Nine ret cycles take stall_cnt from 6 to the all-ones limit.
    repeat (9) applyStimulus(RET, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    applyIdle();
    checkOutput("stallCntMax", 32'(stallCnt), 15);
    applyStimulus(RET, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    applyIdle();
    checkOutput("stallCntSat", 32'(stallCnt), 15);

    applyStimulus(NOP, RN, RN, OPQ, RN, 1'b1, NOP, 2'd2, 2'd0, 1'b0, 1'b0);
    checkOutput("excMBubble", 32'(mBubble), 1);
    checkOutput("excSetCc", 32'(setCc), 0);
    applyStimulus(NOP, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd2, 1'b0, 1'b0);
    checkOutput("wExcWStall", 32'(wStall), 1);
    checkOutput("wExcHalted", 32'(halted), 0);
    applyStimulus(NOP, RN, RN, JXX, RN, 1'b0, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("haltHalted", 32'(halted), 1);
    checkOutput("haltStalls", 32'({fStall, dStall, eStall, mStall, wStall}), 32'h1F);
    checkOutput("haltEBubble", 32'(eBubble), 0);
    applyStimulus(NOP, RN, RN, JXX, RN, 1'b0, NOP, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("haltMpFrozen", 32'(mispredCnt), 1);

    driveReset(1'b0);
    checkOutput("rst2Halted", 32'(halted), 0);
    checkOutput("rst2EBubble", 32'(eBubble), 0);
    checkOutput("rst2StallCnt", 32'(stallCnt), 0);
    checkOutput("rst2MpCnt", 32'(mispredCnt), 0);
    applyIdle();
    driveReset(1'b1);

    // Acknowledge never arrives: HALT five cycles after the request starts.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(NOP, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b1, 1'b0);
      checkOutput("toNotHalted", 32'(halted), 0);
    end
    checkOutput("toFStall", 32'(fStall), 1);
    applyStimulus(NOP, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("toHalted", 32'(halted), 1);
    checkOutput("toMemErr", 32'(memErr), 1);
    checkOutput("toStalls", 32'({fStall, dStall, eStall, mStall, wStall}), 32'h1F);
    checkOutput("toWBubble", 32'(wBubble), 0);
    checkOutput("toStallCnt", 32'(stallCnt), 5);
    applyStimulus(NOP, RN, RN, NOP, RN, 1'b1, NOP, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("toStallCntFrozen", 32'(stallCnt), 5);

    driveReset(1'b0);
    checkOutput("rst3Ctrl", 32'({fStall, dStall, dBubble, eStall, eBubble, mStall, mBubble,
                                 wStall, wBubble, setCc, halted, memErr}), 0);
    applyIdle();
    driveReset(1'b1);
    applyIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Next-generation hazard/control unit for the Y86 5-stage pipeline (F, D, E, M, W).
- Generates stall/bubble/set_cc controls from stage icodes, register IDs and status codes.
- Extends the combinational control with:
  - an RNONE-aware load-use check;
  - a multi-cycle data-memory wait with timeout;
  - a sticky HALT state on exception;
  - saturating hazard performance counters.

Parameters:
- REG_W, 4, register-ID width.
- STAT_W, 2, status width; all-zero means AOK.
- RNONE, 4'hF, "no register" ID, REG_W bits wide.
- MEM_TIMEOUT, 16, maximum consecutive memory-wait cycles before a fatal error (≥1).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_icode  in  4  icode in Decode.
- d_srcA  in  REG_W  decode srcA.
- d_srcB  in  REG_W  decode srcB.
- E_icode  in  4  icode in Execute.
- E_dstM  in  REG_W  Execute dstM.
- e_cnd  in  1  Execute branch condition.
- M_icode  in  4  icode in Memory.
- m_stat  in  STAT_W  Memory-stage status.
- W_stat  in  STAT_W  Writeback status.
- m_mem_req  in  1  Memory stage has an access in progress.
- m_mem_ack  in  1  data memory completes the access this cycle.
- F_stall  out  1  stall Fetch.
- D_stall  out  1  stall Decode.
- D_bubble  out  1  bubble Decode.
- E_stall  out  1  stall Execute.
- E_bubble  out  1  bubble Execute.
- M_stall  out  1  stall Memory.
- M_bubble  out  1  bubble Memory.
- W_stall  out  1  stall Writeback.
- W_bubble  out  1  bubble Writeback.
- set_cc  out  1  condition-code write enable.
- halted  out  1  FSM is in HALT.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  count of F_stall cycles.
- mispred_cnt  out  CNT_W  count of mispredict cycles.
- loaduse_cnt  out  CNT_W  count of load-use cycles.

Behaviour:
- Icodes: mrmovq=5, OPq=6, jXX=7, ret=9, popq=B.
- Hazard terms (combinational):
  - load_use = (E_icode==5 or E_icode==B) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
  - mispred = E_icode==7 and !e_cnd.
  - ret_haz = D_icode==9 or E_icode==9 or M_icode==9.
  - exc = m_stat!=0 or W_stat!=0.
  - mem_hold = m_mem_req and !m_mem_ack.
- FSM states: RUN, MWAIT, HALT. Reset → RUN, wait_cnt=0, mem_err=0, all counters 0.
- Transitions (priority top-down):
  - W_stat!=0 in RUN or MWAIT → HALT.
  - RUN with mem_hold → MWAIT, wait_cnt=1.
  - MWAIT with !mem_hold → RUN, wait_cnt=0.
  - MWAIT with mem_hold and wait_cnt==MEM_TIMEOUT → HALT, mem_err=1.
  - Otherwise in MWAIT, wait_cnt increments.
  - HALT exits only on reset.
- Outputs: combinational from state and inputs; all 0 except where listed below. During reset, every output is 0.
- HALT: halted=1; F_stall, D_stall, E_stall, M_stall and W_stall all =1; set_cc=0.
- RUN/MWAIT with mem_hold:
  - F_stall, D_stall, E_stall and M_stall =1; W_bubble=1; set_cc=0.
  - Hazard controls are suppressed.
  - W_stat!=0 additionally forces W_stall=1 and W_bubble=0.
- Otherwise (no mem_hold):
  - F_stall = load_use or ret_haz.
  - D_stall = load_use.
  - D_bubble = mispred or (ret_haz and !load_use).
  - E_bubble = mispred or load_use.
  - M_bubble = exc.
  - W_stall = W_stat!=0.
  - set_cc = E_icode==6 and m_stat==0 and W_stat==0.
- Simultaneous hazards: signals are the OR of the rules above.
  - Example: ret in D with mispredict in E gives F_stall=1, D_bubble=1, E_bubble=1.
  - D_stall and D_bubble are never both 1.
- Counters:
  - Update on clk edge only when state!=HALT.
  - stall_cnt increments on F_stall; mispred_cnt on mispred with no mem_hold; loaduse_cnt on load_use with no mem_hold.
  - Each counter saturates at all-ones; no wrap.
- Async reset mid-MWAIT or in HALT: immediate return to RUN with counters cleared.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; loaduse_cnt 0→1.
- RNONE filter: E_icode=B, E_dstM=F, d_srcB=F → all stalls and bubbles 0.
- Mispredict + ret: E_icode=7, e_cnd=0, D_icode=9 → F_stall=1, D_bubble=1, E_bubble=1, D_stall=0; mispred_cnt +1.
- Memory wait, MEM_TIMEOUT=4: m_mem_req=1 with ack low for 3 cycles, then ack → F/D/E/M_stall=1 and W_bubble=1 for 3 cycles, then state RUN with no stall; mem_err=0.
- Timeout, MEM_TIMEOUT=4: ack held low → HALT entered 5 cycles after the request began; halted=1, mem_err=1, all five stage stalls =1, counters frozen; rst_n low → all outputs 0.
- Exception: m_stat=2, E_icode=6 → M_bubble=1, set_cc=0. Next, W_stat=2 → W_stall=1; next cycle halted=1.
